// File: rtl/id_hazard_unit.sv
// Decode-stage hazard unit: tracks in-flight destinations, forwards operands, stalls on young loads.
// Optional HAZARD_STAT_EN adds a free-running stall cycle counter output (stall_cnt).
module id_hazard_unit #(
  parameter int DW       = 32,
  parameter int NRD      = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_STG = 2
) (
  input  logic                  cpu_clk_50M,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*5-1:0]      rd_addr,
  input  logic [NRD*DW-1:0]     rf_data,
  input  logic                  iss_valid,
  input  logic                  iss_wreg,
  input  logic [4:0]            iss_wa,
  input  logic                  iss_mreg,
  input  logic [DEPTH*DW-1:0]   stage_wd,
  input  logic                  flush,
  output logic [NRD*DW-1:0]     fwd_data,
  output logic [NRD*3-1:0]      fwd_sel,
  output logic                  stallreq_id
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_RF   = 3'd7;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0][4:0] wa_q, wa_d;
  logic [DEPTH-1:0]      mreg_q, mreg_d;

  logic [NRD*DW-1:0]     fwd_data_s;
  logic [NRD*3-1:0]      fwd_sel_s;
  logic                  stall_s;
  logic                  issue_s;

  // Operand resolution: youngest matching slot wins, loads younger than LOAD_STG stall
  always_comb begin
    logic [4:0]    addr_v;
    logic          hit_v;
    logic          ld_v;
    logic [DW-1:0] data_v;
    logic [2:0]    sel_v;
    stall_s    = 1'b0;
    fwd_data_s = '0;
    fwd_sel_s  = '0;
    addr_v     = 5'd0;
    hit_v      = 1'b0;
    ld_v       = 1'b0;
    data_v     = '0;
    sel_v      = SEL_ZERO;
    for (int p = 0; p < NRD; p++) begin
      addr_v = rd_addr[5*p +: 5];
      hit_v  = 1'b0;
      ld_v   = 1'b0;
      data_v = '0;
      sel_v  = SEL_ZERO;
      // Walk oldest to youngest so the lowest matching index overwrites the rest
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (rd_en[p] && valid_q[k] && (wa_q[k] == addr_v) && (addr_v != 5'd0)) begin
          hit_v  = 1'b1;
          ld_v   = mreg_q[k] && (k < LOAD_STG);
          data_v = stage_wd[DW*k +: DW];
          sel_v  = 3'(k + 1);
        end else begin
          hit_v  = hit_v;
        end
      end
      if (!rd_en[p] || (addr_v == 5'd0)) begin
        fwd_data_s[DW*p +: DW] = '0;
        fwd_sel_s[3*p +: 3]    = SEL_ZERO;
      end else if (hit_v) begin
        fwd_data_s[DW*p +: DW] = data_v;
        fwd_sel_s[3*p +: 3]    = sel_v;
        stall_s                = stall_s | (ld_v & iss_valid);
      end else begin
        fwd_data_s[DW*p +: DW] = rf_data[DW*p +: DW];
        fwd_sel_s[3*p +: 3]    = SEL_RF;
      end
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock
  always_comb begin
    if (rst_n) begin
      fwd_data    = fwd_data_s;
      fwd_sel     = fwd_sel_s;
      stallreq_id = stall_s;
    end else begin
      fwd_data    = '0;
      fwd_sel     = '0;
      stallreq_id = 1'b0;
    end
  end

  assign issue_s = iss_valid & iss_wreg & (iss_wa != 5'd0) & ~stall_s & ~flush;

  // Scoreboard next state: flush clears everything, otherwise shift and insert at slot 0
  always_comb begin
    valid_d = valid_q;
    wa_d    = wa_q;
    mreg_d  = mreg_q;
    if (flush) begin
      valid_d = '0;
      wa_d    = '0;
      mreg_d  = '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        wa_d[k]    = wa_q[k-1];
        mreg_d[k]  = mreg_q[k-1];
      end
      valid_d[0] = issue_s;
      wa_d[0]    = issue_s ? iss_wa : 5'd0;
      mreg_d[0]  = issue_s & iss_mreg;
    end
  end

  // Scoreboard state register
  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wa_q    <= '0;
      mreg_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wa_q    <= wa_d;
      mreg_q  <= mreg_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stallreq_id ? (stall_cnt_q + 32'd1) : stall_cnt_q;

  // Stall cycle counter, wraps naturally at 2^32
  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed self-checking bench for id_hazard_unit (default parameters).
module tb_id_hazard_unit;

  localparam int DW = 32, NRD = 2, DEPTH = 3, LOAD_STG = 2;

  logic                cpu_clk_50M = 1'b0;
  logic                rst_n;
  logic [NRD-1:0]      rd_en;
  logic [NRD*5-1:0]    rd_addr;
  logic [NRD*DW-1:0]   rf_data;
  logic                iss_valid, iss_wreg, iss_mreg, flush;
  logic [4:0]          iss_wa;
  logic [DEPTH*DW-1:0] stage_wd;
  logic [NRD*DW-1:0]   fwd_data;
  logic [NRD*3-1:0]    fwd_sel;
  logic                stallreq_id;
`ifdef HAZARD_STAT_EN
  logic [31:0]         stall_cnt;
  logic [31:0]         cnt0;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [DEPTH*DW-1:0] WD_DEF = {32'h0000_6666, 32'h0000_5555, 32'h0000_1234};
  localparam logic [DEPTH*DW-1:0] WD_T3  = {32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};

  id_hazard_unit #(.DW(DW), .NRD(NRD), .DEPTH(DEPTH), .LOAD_STG(LOAD_STG)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rf_data     (rf_data),
    .iss_valid   (iss_valid),
    .iss_wreg    (iss_wreg),
    .iss_wa      (iss_wa),
    .iss_mreg    (iss_mreg),
    .stage_wd    (stage_wd),
    .flush       (flush),
    .fwd_data    (fwd_data),
    .fwd_sel     (fwd_sel),
    .stallreq_id (stallreq_id)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] wa, input logic m,
                       input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic fl);
    iss_valid = v;
    iss_wreg  = w;
    iss_wa    = wa;
    iss_mreg  = m;
    rd_en     = en;
    rd_addr   = {a1, a0};
    flush     = fl;
  endtask

  task automatic tick();
    @(negedge cpu_clk_50M);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    rf_data  = {32'hF1F1_0001, 32'hF0F0_0000};
    stage_wd = WD_DEF;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd1, 5'd2, 1'b0);
    #2;
    chk("rst_stall", {63'd0, stallreq_id}, 64'd0);
    chk("rst_data", fwd_data, 64'd0);
    chk("rst_sel", {58'd0, fwd_sel}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // addu $3, then read it back as it walks EXE -> MEM -> WB -> register file
    drive(1'b1, 1'b1, 5'd3, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    #2 chk("t1_issue_nostall", {63'd0, stallreq_id}, 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd3, 5'd0, 1'b0);
    #2;
    chk("t1_exe_sel", {58'd0, fwd_sel}, 64'd1);
    chk("t1_exe_data", fwd_data, 64'h0000_0000_0000_1234);
    chk("t1_exe_stall", {63'd0, stallreq_id}, 64'd0);
    tick();
    #2;
    chk("t1_mem_sel", {58'd0, fwd_sel}, 64'd2);
    chk("t1_mem_data", fwd_data, 64'h0000_0000_0000_5555);
    tick();
    #2;
    chk("t1_wb_sel", {58'd0, fwd_sel}, 64'd3);
    chk("t1_wb_data", fwd_data, 64'h0000_0000_0000_6666);
    tick();
    #2;
    chk("t1_rf_sel", {58'd0, fwd_sel}, 64'd7);
    chk("t1_rf_data", fwd_data, 64'h0000_0000_F0F0_0000);
    tick();

    // lw $5 then dependent on port 1: two stall cycles, then WB forward
`ifdef HAZARD_STAT_EN
    cnt0 = stall_cnt;
`endif
    drive(1'b1, 1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd6, 1'b0, 2'b10, 5'd0, 5'd5, 1'b0);
    #2 chk("t2_stall1", {63'd0, stallreq_id}, 64'd1);
    tick();
    #2 chk("t2_stall2", {63'd0, stallreq_id}, 64'd1);
    tick();
    #2;
    chk("t2_release", {63'd0, stallreq_id}, 64'd0);
    chk("t2_wb_sel", {58'd0, fwd_sel}, 64'd24);
    chk("t2_wb_data", fwd_data, 64'h0000_6666_0000_0000);
    tick();
`ifdef HAZARD_STAT_EN
    chk("t2_stall_cnt", {32'd0, stall_cnt - cnt0}, 64'd2);
`endif
    idle(3);

    // $7 in EXE and MEM: both ports take the youngest
    drive(1'b1, 1'b1, 5'd7, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd7, 5'd7, 1'b0);
    stage_wd = WD_T3;
    #2;
    chk("t3_data", fwd_data, 64'h0000_AAAA_0000_AAAA);
    chk("t3_sel", {58'd0, fwd_sel}, 64'd9);
    tick();
    stage_wd = WD_DEF;
    idle(3);

    // write to $0 is not tracked; reading $0 yields zero
    drive(1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd0, 5'd9, 1'b0);
    #2;
    chk("t4_data", fwd_data, 64'hF1F1_0001_0000_0000);
    chk("t4_sel", {58'd0, fwd_sel}, 64'd56);
    tick();

    // add $4 then lw $4: the younger load must stall; flush that same cycle
    drive(1'b1, 1'b1, 5'd4, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd8, 1'b0, 2'b01, 5'd4, 5'd0, 1'b1);
    #2 chk("t5_young_load_stall", {63'd0, stallreq_id}, 64'd1);
    tick();
    drive(1'b1, 1'b1, 5'd8, 1'b0, 2'b11, 5'd4, 5'd8, 1'b0);
    #2;
    chk("t5_post_flush_stall", {63'd0, stallreq_id}, 64'd0);
    chk("t5_post_flush_sel", {58'd0, fwd_sel}, 64'd63);
    chk("t5_post_flush_data", fwd_data, 64'hF1F1_0001_F0F0_0000);
    tick();
    idle(3);

    // lw $10, stall, then asynchronous reset between edges
    drive(1'b1, 1'b1, 5'd10, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd10, 5'd0, 1'b0);
    #2 chk("t6_no_valid_no_stall", {63'd0, stallreq_id}, 64'd0);
    tick();
    drive(1'b1, 1'b1, 5'd11, 1'b0, 2'b01, 5'd10, 5'd0, 1'b0);
    #2 chk("t6_stall", {63'd0, stallreq_id}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", {63'd0, stallreq_id}, 64'd0);
    chk("t6_rst_data", fwd_data, 64'd0);
    chk("t6_rst_sel", {58'd0, fwd_sel}, 64'd0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("t6_after_stall", {63'd0, stallreq_id}, 64'd0);
    chk("t6_after_sel", {58'd0, fwd_sel}, 64'd7);
    chk("t6_after_data", fwd_data, 64'h0000_0000_F0F0_0000);
`ifdef HAZARD_STAT_EN
    chk("t6_stall_cnt_rst", {32'd0, stall_cnt}, 64'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
